// File: rtl/demux32_1_2.sv
// Registered 1-to-2 demultiplexer with independent valid/ready output slots.
// Optional per-side transfer counters are built when DEMUX32_CNT_EN is defined.
module demux32_1_2 #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] I,
    input  logic             I_valid,
    output logic             I_ready,
    input  logic             Sel,
    output logic [WIDTH-1:0] OA,
    output logic             OA_valid,
    input  logic             OA_ready,
    output logic [WIDTH-1:0] OB,
    output logic             OB_valid,
    input  logic             OB_ready,
    output logic [CNT_W-1:0] CNT_A,
    output logic [CNT_W-1:0] CNT_B
);

    logic [WIDTH-1:0] oa_q, oa_d;
    logic [WIDTH-1:0] ob_q, ob_d;
    logic             oa_valid_q, oa_valid_d;
    logic             ob_valid_q, ob_valid_d;
    logic             load_a, load_b;
    logic             drain_a, drain_b;

    // Only the selected slot gates the input, so a stalled idle side never blocks.
    always_comb begin
        I_ready = Sel ? (!ob_valid_q || OB_ready) : (!oa_valid_q || OA_ready);
        load_a  = I_valid && I_ready && !Sel;
        load_b  = I_valid && I_ready &&  Sel;
        drain_a = oa_valid_q && OA_ready;
        drain_b = ob_valid_q && OB_ready;
    end

    always_comb begin
        oa_d       = oa_q;
        ob_d       = ob_q;
        oa_valid_d = load_a || (oa_valid_q && !drain_a);
        ob_valid_d = load_b || (ob_valid_q && !drain_b);
        if (load_a) oa_d = I;
        if (load_b) ob_d = I;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oa_q       <= '0;
            ob_q       <= '0;
            oa_valid_q <= 1'b0;
            ob_valid_q <= 1'b0;
        end else begin
            oa_q       <= oa_d;
            ob_q       <= ob_d;
            oa_valid_q <= oa_valid_d;
            ob_valid_q <= ob_valid_d;
        end
    end

    always_comb begin
        OA       = oa_q;
        OB       = ob_q;
        OA_valid = oa_valid_q;
        OB_valid = ob_valid_q;
    end

`ifdef DEMUX32_CNT_EN
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (drain_a) cnt_a_d = cnt_a_q + CNT_W'(1);
        if (drain_b) cnt_b_d = cnt_b_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    always_comb begin
        CNT_A = cnt_a_q;
        CNT_B = cnt_b_q;
    end
`else
    always_comb begin
        CNT_A = '0;
        CNT_B = '0;
    end
`endif

endmodule
